// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one ram port between the icache and the dcache.
// The dcache normally wins; a starvation counter forces an icache grant
// after STARVE_MAX back-to-back dcache grants while the icache waits.
// Ram strobes are driven only from a registered grant, never straight
// from the requests, so a request reaches the ram one cycle later at best.
module mem_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int BURST_MAX  = 2
) (
   input  logic        CLK,
   input  logic        nRST,
   // icache side
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   // dcache side
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   // ram side
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] GRANT_I = 2'd1;
   localparam logic [1:0] GRANT_D = 2'd2;

   localparam logic [1:0] RAM_ACCESS = 2'd2;

   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
   // word_cnt value at which the completing ACCESS ends the burst
   localparam logic [1:0] BURST_LAST = 2'(BURST_MAX - 1);

   logic [1:0] state_q, state_d;
   logic [2:0] starve_cnt_q, starve_cnt_d;
   logic [1:0] word_cnt_q, word_cnt_d;

   logic       acc;
   logic       d_req;
   logic       i_starved;

   assign acc       = (ramstate == RAM_ACCESS);
   assign d_req     = dREN | dWEN;
   assign i_starved = iREN && (starve_cnt_q == STARVE_LIM);

   // Next grant, burst word count and icache starvation count.
   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      word_cnt_d   = word_cnt_q;
      case (state_q)
         IDLE: begin
            if (d_req && !i_starved) begin
               state_d    = GRANT_D;
               word_cnt_d = 2'd0;
               // i_starved is false here, so the count is below its limit
               if (iREN) starve_cnt_d = starve_cnt_q + 3'd1;
               else      starve_cnt_d = 3'd0;
            end else if (iREN) begin
               state_d      = GRANT_I;
               starve_cnt_d = 3'd0;
            end else begin
               starve_cnt_d = 3'd0;
            end
         end
         GRANT_I: begin
            if (acc || !iREN) state_d = IDLE;
         end
         GRANT_D: begin
            if (acc) word_cnt_d = word_cnt_q + 2'd1;
            if (!d_req)                           state_d = IDLE;
            else if (acc && word_cnt_q == BURST_LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Grant state and counters; reset abandons any transaction in flight.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= IDLE;
         starve_cnt_q <= 3'd0;
         word_cnt_q   <= 2'd0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         word_cnt_q   <= word_cnt_d;
      end
   end

   // Ram port mux and stall signals; addresses are forwarded live, not latched.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = 32'd0;
      ramstore = 32'd0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      case (state_q)
         GRANT_I: begin
            ramREN  = iREN;
            ramaddr = iaddr;
            iwait   = ~acc;
         end
         GRANT_D: begin
            ramREN   = dREN;
            ramWEN   = dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            dwait    = ~acc;
         end
         default: ;
      endcase
   end

   // Read data goes to both caches; the wait lines tell who owns it.
   assign iload = ramload;
   assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a cycle-by-cycle vector table (reset, icache read,
// dcache burst, priority, starvation, ram error hold) plus hand sequences
// for reset behaviour.
module tb_mem_arbiter;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [1:0]  ramstate;
   logic        iwait, dwait, ramREN, ramWEN;
   logic [31:0] iload, dload, ramaddr, ramstore;

   localparam logic [1:0] FR = 2'd0, BS = 2'd1, AC = 2'd2, ER = 2'd3;

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   mem_arbiter #(.STARVE_MAX(4), .BURST_MAX(2)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   typedef struct {
      logic        iren;
      logic [31:0] iaddr;
      logic        dren;
      logic        dwen;
      logic [31:0] daddr;
      logic [31:0] dstore;
      logic [1:0]  rst;
      logic [31:0] rload;
      logic        e_rren;
      logic        e_rwen;
      logic [31:0] e_raddr;
      logic [31:0] e_rstore;
      logic        e_iw;
      logic        e_dw;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   task automatic add(input logic ir, input logic [31:0] ia, input logic dr,
                      input logic dw, input logic [31:0] da, input logic [31:0] ds,
                      input logic [1:0] rs, input logic [31:0] rl,
                      input logic err, input logic ewr, input logic [31:0] eadr,
                      input logic [31:0] est, input logic eiw, input logic edw);
      vec_t v;
      v.iren = ir; v.iaddr = ia; v.dren = dr; v.dwen = dw; v.daddr = da;
      v.dstore = ds; v.rst = rs; v.rload = rl;
      v.e_rren = err; v.e_rwen = ewr; v.e_raddr = eadr; v.e_rstore = est;
      v.e_iw = eiw; v.e_dw = edw;
      tbl.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      iREN = v.iren; iaddr = v.iaddr; dREN = v.dren; dWEN = v.dwen;
      daddr = v.daddr; dstore = v.dstore; ramstate = v.rst; ramload = v.rload;
      sb.push_back(v);
   endtask

   task automatic compare(input int idx);
      vec_t e;
      e = sb.pop_front();
      n_vec++;
      if (ramREN !== e.e_rren || ramWEN !== e.e_rwen || ramaddr !== e.e_raddr ||
          ramstore !== e.e_rstore || iwait !== e.e_iw || dwait !== e.e_dw ||
          iload !== e.rload || dload !== e.rload) begin
         n_err++;
         $display("FAIL vec%0d: got ren=%b wen=%b addr=%h st=%h iw=%b dw=%b il=%h dl=%h exp ren=%b wen=%b addr=%h st=%h iw=%b dw=%b ld=%h",
                  idx, ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload,
                  e.e_rren, e.e_rwen, e.e_raddr, e.e_rstore, e.e_iw, e.e_dw, e.rload);
      end
   endtask

   task automatic chk(input string nm, input logic err, input logic ewr,
                      input logic eiw, input logic edw);
      n_vec++;
      if (ramREN !== err || ramWEN !== ewr || iwait !== eiw || dwait !== edw) begin
         n_err++;
         $display("FAIL %s: got ren=%b wen=%b iw=%b dw=%b exp ren=%b wen=%b iw=%b dw=%b",
                  nm, ramREN, ramWEN, iwait, dwait, err, ewr, eiw, edw);
      end
   endtask

   initial begin
      // ---- table: one row per cycle, applied back-to-back from reset ----
      // icache read: BUSY then ACCESS
      add(1, 32'h40, 0, 0, 0, 0, FR, 32'hDEADBEEF, 0, 0, 32'h0,  0, 1, 1);
      add(1, 32'h40, 0, 0, 0, 0, BS, 32'hDEADBEEF, 1, 0, 32'h40, 0, 1, 1);
      add(1, 32'h40, 0, 0, 0, 0, AC, 32'hDEADBEEF, 1, 0, 32'h40, 0, 0, 1);
      add(0, 32'h40, 0, 0, 0, 0, FR, 32'h0,        0, 0, 32'h0,  0, 1, 1);
      // dcache two-word burst, address advanced by the requester
      add(0, 0, 1, 0, 32'h100, 0, FR, 32'h0,  0, 0, 32'h0,   0, 1, 1);
      add(0, 0, 1, 0, 32'h100, 0, BS, 32'h0,  1, 0, 32'h100, 0, 1, 1);
      add(0, 0, 1, 0, 32'h100, 0, AC, 32'h11, 1, 0, 32'h100, 0, 1, 0);
      add(0, 0, 1, 0, 32'h104, 0, BS, 32'h0,  1, 0, 32'h104, 0, 1, 1);
      add(0, 0, 1, 0, 32'h104, 0, AC, 32'h22, 1, 0, 32'h104, 0, 1, 0);
      add(0, 0, 0, 0, 32'h104, 0, FR, 32'h0,  0, 0, 32'h0,   0, 1, 1);
      // simultaneous iREN and dWEN: write first, then icache
      add(1, 32'h80, 0, 1, 32'h3100, 5, FR, 32'h0,  0, 0, 32'h0,    0, 1, 1);
      add(1, 32'h80, 0, 1, 32'h3100, 5, AC, 32'h0,  0, 1, 32'h3100, 5, 1, 0);
      add(1, 32'h80, 0, 0, 32'h3100, 5, FR, 32'h0,  0, 0, 32'h3100, 5, 1, 1);
      add(1, 32'h80, 0, 0, 32'h3100, 5, FR, 32'h0,  0, 0, 32'h0,    0, 1, 1);
      add(1, 32'h80, 0, 0, 32'h3100, 5, AC, 32'h77, 1, 0, 32'h80,   0, 0, 1);
      add(0, 32'h80, 0, 0, 32'h3100, 5, FR, 32'h0,  0, 0, 32'h0,    0, 1, 1);
      // starvation: four dcache grants of two words, then the icache
      for (int g = 0; g < 4; g++) begin
         add(1, 32'h200, 1, 0, 32'h300, 0, AC, 32'hAB, 0, 0, 32'h0,   0, 1, 1);
         add(1, 32'h200, 1, 0, 32'h300, 0, AC, 32'hAB, 1, 0, 32'h300, 0, 1, 0);
         add(1, 32'h200, 1, 0, 32'h300, 0, AC, 32'hAB, 1, 0, 32'h300, 0, 1, 0);
      end
      add(1, 32'h200, 1, 0, 32'h300, 0, AC, 32'hAB, 0, 0, 32'h0,   0, 1, 1);
      add(1, 32'h200, 1, 0, 32'h300, 0, AC, 32'hAB, 1, 0, 32'h200, 0, 0, 1);
      // count restarted: dcache wins again
      add(1, 32'h200, 1, 0, 32'h300, 0, AC, 32'hAB, 0, 0, 32'h0,   0, 1, 1);
      add(1, 32'h200, 1, 0, 32'h300, 0, AC, 32'hAB, 1, 0, 32'h300, 0, 1, 0);
      add(0, 32'h200, 0, 0, 32'h300, 0, FR, 32'h0,  0, 0, 32'h300, 0, 1, 1);
      add(0, 32'h200, 0, 0, 32'h300, 0, FR, 32'h0,  0, 0, 32'h0,   0, 1, 1);
      // ram ERROR for 10 cycles during an icache grant: held, no timeout
      add(1, 32'h44, 0, 0, 0, 0, FR, 32'h0, 0, 0, 32'h0, 0, 1, 1);
      for (int k = 0; k < 10; k++)
         add(1, 32'h44, 0, 0, 0, 0, ER, 32'h5A, 1, 0, 32'h44, 0, 1, 1);
      add(1, 32'h44, 0, 0, 0, 0, AC, 32'h99, 1, 0, 32'h44, 0, 0, 1);
      add(0, 32'h44, 0, 0, 0, 0, FR, 32'h0,  0, 0, 32'h0,  0, 1, 1);

      // ---- reset state with requests already asserted ----
      nRST = 1'b0;
      iREN = 1; iaddr = 32'h40; dREN = 0; dWEN = 1; daddr = 32'h10; dstore = 32'h1;
      ramstate = AC; ramload = 0;
      @(posedge CLK);
      @(negedge CLK);
      chk("reset_hold", 0, 0, 1, 1);
      iREN = 0; dWEN = 0;
      @(posedge CLK);
      #1 nRST = 1'b1;

      // ---- table ----
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         @(negedge CLK);
         compare(i);
         @(posedge CLK);
         #1;
      end

      // ---- reset pulsed during a dcache write ----
      iREN = 0; dREN = 0; dWEN = 1; daddr = 32'h500; dstore = 32'h9; ramstate = BS;
      @(negedge CLK);
      chk("wr_idle", 0, 0, 1, 1);
      @(posedge CLK);
      #1;
      @(negedge CLK);
      chk("wr_grant", 0, 1, 1, 1);
      #1 nRST = 1'b0;
      #1 chk("wr_rst_async", 0, 0, 1, 1);
      @(posedge CLK);
      @(negedge CLK);
      chk("wr_rst_held", 0, 0, 1, 1);
      #1 nRST = 1'b1;
      #1 chk("wr_rst_release", 0, 0, 1, 1);
      @(posedge CLK);
      #1 chk("wr_regrant", 0, 1, 1, 1);
      dWEN = 0;
      @(posedge CLK);
      #1 chk("wr_done", 0, 0, 1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, max consecutive dcache grants while iREN pending.
REQ-002 Parameter BURST_MAX, default 2, max ram words per dcache grant.
REQ-003 CLK  in  1  system clock, rising edge.
REQ-004 nRST  in  1  asynchronous active-low reset.
REQ-005 iREN  in  1  icache read request.
REQ-006 iaddr  in  32  icache word address.
REQ-007 iwait  out  1  icache stall; low for exactly the cycle iload is valid.
REQ-008 iload  out  32  icache read data.
REQ-009 dREN, dWEN  in  1 each  dcache read/write request; never both high.
REQ-010 daddr, dstore  in  32 each  dcache address / write data.
REQ-011 dwait  out  1  dcache stall; low for exactly the cycle the word completes.
REQ-012 dload  out  32  dcache read data.
REQ-013 ramREN, ramWEN  out  1 each  ram strobes.
REQ-014 ramaddr, ramstore  out  32 each  ram address / write data.
REQ-015 ramload  in  32  ram read data.
REQ-016 ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-017 States: IDLE, GRANT_I, GRANT_D; state registered.
REQ-018 IDLE: all ram strobes 0, ramaddr/ramstore 0, iwait=1, dwait=1; no combinational pass-through, so min latency request->ram strobe is 1 cycle.
REQ-019 IDLE->GRANT_D if (dREN|dWEN) and not (iREN and starve_cnt==STARVE_MAX); else IDLE->GRANT_I if iREN; else stay.
REQ-020 GRANT_I: ramREN=iREN, ramaddr=iaddr, ramWEN=0; iwait=~(ramstate==ACCESS); dwait=1.
REQ-021 GRANT_I->IDLE on the ACCESS cycle or if iREN drops; starve_cnt cleared on entry to GRANT_I.
REQ-022 GRANT_D: ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore; dwait=~(ramstate==ACCESS); iwait=1.
REQ-023 GRANT_D word_cnt (2 bits) increments on each ACCESS cycle, cleared on entry.
REQ-024 GRANT_D->IDLE when dREN and dWEN both low, or on the ACCESS cycle that makes word_cnt==BURST_MAX.
REQ-025 starve_cnt (3 bits) increments on entry to GRANT_D when iREN high, saturates at STARVE_MAX, cleared when iREN low in IDLE.
REQ-026 iload=ramload and dload=ramload unconditionally (combinational).
REQ-027 ramstate ERROR or BUSY or FREE: owner wait stays 1, state held; no timeout.
REQ-028 Requester address change mid-grant is forwarded to ramaddr the same cycle; arbiter does not latch addresses.
REQ-029 Simultaneous iREN and dREN in IDLE with starve_cnt<STARVE_MAX: dcache wins.

Reset
REQ-030 nRST low asynchronously forces IDLE, starve_cnt=0, word_cnt=0; all ram strobes 0, iwait=1, dwait=1 while low.
REQ-031 Reset mid-grant abandons the transaction; no ram strobe in the cycle after nRST rises.

Verification
REQ-032 iREN=1, iaddr=0x40, ramstate=ACCESS after 2 cycles, ramload=0xDEADBEEF -> ramREN=1 from cycle 1, iwait=0 with iload=0xDEADBEEF for one cycle, then IDLE.
REQ-033 dREN held 2 words at 0x100/0x104, ramload 0x11/0x22 -> dwait low twice, dload 0x11 then 0x22, returns to IDLE after second ACCESS.
REQ-034 iREN and dWEN both high in IDLE, daddr=0x3100, dstore=5 -> GRANT_D first, ramWEN=1 ramstore=5; GRANT_I follows.
REQ-035 dREN high continuously with iREN high, ramstate always ACCESS -> after 4 dcache grants the 5th grant goes to icache; starve_cnt back to 0.
REQ-036 nRST pulsed low during GRANT_D with ramWEN=1 -> ramWEN=0 immediately, IDLE after release, dwait=1.
REQ-037 ramstate=ERROR for 10 cycles in GRANT_I -> iwait stays 1, state GRANT_I, ramREN=1 throughout.
